// File: rtl/soc_bram_dma_pkg.sv
// Shared constants for the BRAM copy engine: bus direction codes and
// the 3-bit state encodings of the copy sequencer.
package soc_bram_dma_pkg;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

endpackage

// File: rtl/soc_bram_dma.sv
// Word-by-word memory copy engine on the single-beat SoC bus.
// Each word is one read beat followed by one write beat. Every bus output
// is registered, so the strobe for a beat is set up on the edge that enters
// its request state. A per-beat timeout aborts the copy with a sticky error.
module soc_bram_dma
    import soc_bram_dma_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_dwrite,
    output logic              o_rw,
    output logic              o_stb,
    input  logic              i_ack,
    input  logic [31:0]       i_dread
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_wbuf;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic              r_stb;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_timeout;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_src_next;
    logic [ADDR_W-1:0] w_dst_next;

    // Wait budget exhausted, last word in flight, and wrapping word steps.
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_last_word = (r_rem == LEN_W'(1));
    assign w_src_next  = r_src + ADDR_W'(4);
    assign w_dst_next  = r_dst + ADDR_W'(4);

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_addr   = r_addr;
    assign o_dwrite = r_wbuf;
    assign o_rw     = r_rw;
    assign o_stb    = r_stb;

    // Copy sequencer; strobe and done are single-cycle pulses by default.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_wbuf  <= '0;
            r_addr  <= '0;
            r_rw    <= BUS_RD;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_stb  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src  <= i_src;
                        r_dst  <= i_dst;
                        r_rem  <= i_len;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_stb   <= 1'b1;
                            r_rw    <= BUS_RD;
                            r_addr  <= i_src;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (i_ack) begin
                        // Read data goes straight out as the write payload.
                        r_wbuf  <= i_dread;
                        r_stb   <= 1'b1;
                        r_rw    <= BUS_WR;
                        r_addr  <= r_dst;
                        r_state <= S_WR_REQ;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (i_ack) begin
                        r_src <= w_src_next;
                        r_dst <= w_dst_next;
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_stb   <= 1'b1;
                            r_rw    <= BUS_RD;
                            r_addr  <= w_src_next;
                            r_state <= S_RD_REQ;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bram_dma.sv
// Bench for soc_bram_dma: a byte-addressed memory responder with one-cycle
// ack (switchable to never-ack), a byte-array reference copy model that
// predicts every bus beat and the final memory image, table vectors and
// random transfers, plus timeout and mid-transfer reset sequences.
module tb_soc_bram_dma;

    logic        i_clk, i_reset, i_start;
    logic [7:0]  i_src, i_dst;
    logic [5:0]  i_len;
    logic        o_busy, o_done, o_err, o_rw, o_stb;
    logic [7:0]  o_addr;
    logic [31:0] o_dwrite;
    logic        i_ack;
    logic [31:0] i_dread;

    soc_bram_dma #(.ADDR_W(8), .LEN_W(6), .TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_src(i_src), .i_dst(i_dst), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_addr(o_addr), .o_dwrite(o_dwrite), .o_rw(o_rw), .o_stb(o_stb),
        .i_ack(i_ack), .i_dread(i_dread)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Responder memory, plus a host port used to preload it.
    logic [7:0]  mem [256];
    logic        stub_mode;
    logic        h_we;
    logic [7:0]  h_addr, h_data;

    // One-cycle-ack responder; in stub mode it never answers.
    always @(posedge i_clk) begin
        if (h_we) mem[h_addr] <= h_data;
        i_ack <= 1'b0;
        if (o_stb && !stub_mode) begin
            i_ack <= 1'b1;
            if (o_rw) begin
                for (int b = 0; b < 4; b++) mem[8'(o_addr + b)] <= o_dwrite[8*b +: 8];
            end else begin
                i_dread <= {mem[8'(o_addr + 3)], mem[8'(o_addr + 2)],
                            mem[8'(o_addr + 1)], mem[8'(o_addr)]};
            end
        end
    end

    typedef struct {
        bit          rw;
        logic [7:0]  addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        int         len;
        int         pre;
        int         off;
        int         nstb;
    } vec_t;

    logic [7:0] ref_mem [256];
    beat_t      exp_q[$];
    logic [7:0] rd_addrs[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, done_cyc = 0, n_stb = 0, n_wr = 0;
    bit done_seen = 0, err_at_done = 0, prev_stb = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance one cycle and watch the bus against the predicted beats.
    task automatic step();
        beat_t b;
        @(posedge i_clk); #1;
        cyc++;
        if (o_stb) begin
            n_stb++;
            if (o_rw) n_wr++; else rd_addrs.push_back(o_addr);
            chk(!prev_stb, "stb_back_to_back", 32'(prev_stb), 0);
            if (exp_q.size() == 0) begin
                chk(0, "stb_unexpected", 32'(o_addr), 0);
            end else begin
                b = exp_q.pop_front();
                chk(o_rw == b.rw && o_addr == b.addr && (!b.rw || o_dwrite == b.data),
                    "beat", {o_addr, 7'd0, o_rw, 16'd0} ^ (o_rw ? o_dwrite : 32'd0),
                    {b.addr, 7'd0, b.rw, 16'd0} ^ (b.rw ? b.data : 32'd0));
                if (b.rw)
                    $display("beat WR addr=%02h data=%08h exp=%08h", o_addr, o_dwrite, b.data);
                else
                    $display("beat RD addr=%02h exp=%02h", o_addr, b.addr);
            end
        end
        if (o_done && !done_seen) begin
            done_seen   = 1;
            done_cyc    = cyc;
            err_at_done = o_err;
        end
        prev_stb = o_stb;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        h_we = 1; h_addr = a; h_data = d;
        ref_mem[a] = d;
        step();
        h_we = 0;
    endtask

    // Reference copy: forward word-by-word on the byte image, modulo 256.
    task automatic model_build(input logic [7:0] src, input logic [7:0] dst, input int n);
        beat_t b;
        logic [7:0] ra, wa;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            ra = src + 8'(4 * i);
            wa = dst + 8'(4 * i);
            w = '0;
            for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(ra + k)];
            b.rw = 0; b.addr = ra; b.data = '0; exp_q.push_back(b);
            b.rw = 1; b.addr = wa; b.data = w;  exp_q.push_back(b);
            for (int k = 0; k < 4; k++) ref_mem[8'(wa + k)] = w[8*k +: 8];
        end
    endtask

    task automatic run_xfer(input logic [7:0] src, input logic [7:0] dst, input int len,
                            output int off, output int nstb, output bit err);
        int start_cyc;
        i_src = src; i_dst = dst; i_len = 6'(len); i_start = 1;
        start_cyc = cyc; n_stb = 0; n_wr = 0; done_seen = 0;
        rd_addrs.delete();
        step();
        i_start = 0;
        chk(o_busy == 1, "busy_rise", 32'(o_busy), 1);
        chk(o_err == 0, "err_clear_on_start", 32'(o_err), 0);
        for (int t = 0; t < 300 && !done_seen; t++) step();
        if (!done_seen) chk(0, "done_wait_expired", 0, 1);
        step();
        chk(o_busy == 0 && o_done == 0, "busy_done_low_after", {o_busy, o_done}, 0);
        chk(exp_q.size() == 0, "beats_outstanding", exp_q.size(), 0);
        exp_q.delete();
        off = done_cyc - start_cyc; nstb = n_stb; err = err_at_done;
        $display("xfer src=%02h dst=%02h len=%0d done_off=%0d strobes=%0d err=%0d",
                 src, dst, len, off, nstb, err);
    endtask

    task automatic mem_cmp(input string name);
        int nbad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) nbad++;
        chk(nbad == 0, name, nbad, 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({o_busy, o_done, o_err, o_stb, o_rw} == 5'b0, name, {o_busy, o_done, o_err, o_stb, o_rw}, 0);
        chk(o_addr == 8'h00 && o_dwrite == 32'h0, {name, "_bus"}, o_dwrite ^ 32'(o_addr), 0);
    endtask

    vec_t vecs[6];
    logic [31:0] plan_words [4];
    logic [7:0]  plan_bytes [4];

    initial begin
        int off, nstb;
        bit err;
        logic [7:0] b80;
        logic [7:0] rs, rd;
        int rl;

        vecs[0] = '{src: 8'h00, dst: 8'h40, len: 4, pre: 1, off: 17, nstb: 8};
        vecs[1] = '{src: 8'h01, dst: 8'h81, len: 1, pre: 2, off: 5,  nstb: 2};
        vecs[2] = '{src: 8'h20, dst: 8'h30, len: 0, pre: 0, off: 1,  nstb: 0};
        vecs[3] = '{src: 8'hFC, dst: 8'h10, len: 2, pre: 0, off: 9,  nstb: 4};
        vecs[4] = '{src: 8'h10, dst: 8'h14, len: 3, pre: 0, off: 13, nstb: 6};
        vecs[5] = '{src: 8'h44, dst: 8'h40, len: 2, pre: 0, off: 9,  nstb: 4};
        plan_words[0] = 32'h00112233; plan_words[1] = 32'h44556677;
        plan_words[2] = 32'h8899AABB; plan_words[3] = 32'hCCDDEEFF;
        plan_bytes[0] = 8'h11; plan_bytes[1] = 8'h22; plan_bytes[2] = 8'h33; plan_bytes[3] = 8'h44;

        i_reset = 1; i_start = 0; i_src = 0; i_dst = 0; i_len = 0;
        stub_mode = 0; h_we = 0; h_addr = 0; h_data = 0;
        repeat (3) step();
        chk_reset_outputs("reset_state");
        i_reset = 0;

        for (int a = 0; a < 256; a++) host_wr(8'(a), 8'($urandom_range(0, 255)));

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre == 1)
                for (int w = 0; w < 4; w++)
                    for (int k = 0; k < 4; k++) host_wr(8'(4 * w + k), plan_words[w][8*k +: 8]);
            if (vecs[i].pre == 2)
                for (int k = 0; k < 4; k++) host_wr(8'(1 + k), plan_bytes[k]);
            b80 = mem[8'h80];
            model_build(vecs[i].src, vecs[i].dst, vecs[i].len);
            run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, off, nstb, err);
            chk(off == vecs[i].off, "done_cycle", off, vecs[i].off);
            chk(nstb == vecs[i].nstb, "strobe_count", nstb, vecs[i].nstb);
            chk(err == 0, "err_at_done", 32'(err), 0);
            mem_cmp("mem_image");
            if (vecs[i].pre == 1)
                for (int w = 0; w < 4; w++)
                    chk({mem[8'h43 + 8'(4*w)], mem[8'h42 + 8'(4*w)], mem[8'h41 + 8'(4*w)], mem[8'h40 + 8'(4*w)]}
                        == plan_words[w], "plan_copy_word",
                        {mem[8'h43 + 8'(4*w)], mem[8'h42 + 8'(4*w)], mem[8'h41 + 8'(4*w)], mem[8'h40 + 8'(4*w)]},
                        plan_words[w]);
            if (vecs[i].pre == 2) begin
                for (int k = 0; k < 4; k++)
                    chk(mem[8'(8'h81 + k)] == plan_bytes[k], "unaligned_byte", mem[8'(8'h81 + k)], plan_bytes[k]);
                chk(mem[8'h80] == b80, "unaligned_byte80_kept", mem[8'h80], b80);
            end
            if (i == 3) chk(rd_addrs.size() == 2 && rd_addrs[1] == 8'h00, "wrap_second_read",
                            rd_addrs.size() == 2 ? 32'(rd_addrs[1]) : 32'hFFFF, 0);
        end

        // Responder that never acks: one read strobe, then timeout.
        stub_mode = 1;
        exp_q.push_back('{rw: 0, addr: 8'h10, data: 32'h0});
        run_xfer(8'h10, 8'h20, 3, off, nstb, err);
        chk(nstb == 1, "timeout_strobes", nstb, 1);
        chk(off == 18, "timeout_done_cycle", off, 18);
        chk(err == 1, "timeout_err", 32'(err), 1);
        step();
        chk(o_err == 1, "err_sticky", 32'(o_err), 1);
        stub_mode = 0;
        repeat (2) step();
        model_build(8'h00, 8'h60, 1);
        run_xfer(8'h00, 8'h60, 1, off, nstb, err);
        chk(err == 0 && off == 5, "after_timeout_ok", {31'd0, err} + 32'(off), 5);
        mem_cmp("mem_after_timeout");

        // Reset asserted during the second write strobe.
        model_build(8'h00, 8'h40, 2);
        i_src = 8'h00; i_dst = 8'h40; i_len = 6'd4; i_start = 1;
        n_stb = 0; n_wr = 0; done_seen = 0;
        step();
        i_start = 0;
        for (int t = 0; t < 50 && !(o_stb && o_rw && n_wr == 2); t++) step();
        chk(o_stb && o_rw && n_wr == 2, "second_write_seen", n_wr, 2);
        i_reset = 1;
        step();
        chk_reset_outputs("reset_midxfer");
        i_reset = 0;
        nstb = n_stb;
        repeat (20) step();
        chk(n_stb == nstb, "no_stb_after_reset", n_stb, nstb);
        chk(done_seen == 0, "no_done_after_reset", 32'(done_seen), 0);
        mem_cmp("mem_after_reset");
        model_build(8'h80, 8'hA0, 2);
        run_xfer(8'h80, 8'hA0, 2, off, nstb, err);
        chk(off == 9 && nstb == 4, "start_after_reset", off, 9);

        // Random transfers against the reference copy model.
        for (int r = 0; r < 12; r++) begin
            rs = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            rl = $urandom_range(0, 7);
            model_build(rs, rd, rl);
            run_xfer(rs, rd, rl, off, nstb, err);
            chk(off == 4 * rl + 1, "rand_done_cycle", off, 4 * rl + 1);
            chk(nstb == 2 * rl, "rand_strobes", nstb, 2 * rl);
            chk(err == 0, "rand_err", 32'(err), 0);
            mem_cmp("rand_mem_image");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
